// File: rtl/servo_ctrl_pkg.sv
// servo_ctrl_pkg
// Shared definitions for the dispenser servo controller:
//   - state_e      : controller state encoding (IDLE / EXTEND / RETRACT)
//   - TIMER_W      : width of the shared phase timer
//   - ms_to_cycles : converts a duration in ms to clock cycles
package servo_ctrl_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXTEND  = 2'd1,
    ST_RETRACT = 2'd2
  } state_e;

  // Whole kHz first so that the product stays exact for round clock rates.
  function automatic longint unsigned ms_to_cycles(input longint unsigned clk_freq,
                                                   input longint unsigned ms);
    return (clk_freq / 64'd1000) * ms;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// dispense_timer
// Loadable up-counter shared by the EXTEND and RETRACT phases.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : force the count to zero (highest priority)
//   load       : load load_value into the count
//   load_value : value loaded when load is high
//   enable     : count up by one per cycle
//   term_cnt   : phase length in cycles (must be >= 1)
//   expire     : high on the final cycle of the phase (count == term_cnt-1)
module dispense_timer
  import servo_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               enable,
  input  logic [TIMER_W-1:0] term_cnt,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear beats load, load beats counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag the last cycle of the phase so the owner can switch phase on that edge.
  assign expire = enable && (count_q == (term_cnt - TIMER_W'(1)));

endmodule

// File: rtl/servo_dispense_ctrl.sv
// servo_dispense_ctrl
// Drives one dispenser servo through push/retract cycles until the requested
// number of items has been released.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : request valid (held by the requester until accepted)
//   req_qty         : number of items, sampled on accept
//   req_ready       : controller is idle and can accept a request
//   position_select : 1 = push (180 deg), 0 = rest (0 deg)
//   busy            : a dispense sequence is running
//   items_left      : items remaining including the one in progress
//   done            : one-cycle pulse when a request completes
//   total_dispensed : saturating count of completed pushes
//                     (only when SERVO_DISPENSE_TOTAL_EN is defined)
// Optional build macro: SERVO_DISPENSE_TOTAL_EN
module servo_dispense_ctrl
  import servo_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned HOLD_MS   = 500,
  parameter int unsigned RETURN_MS = 500,
  parameter int          QTY_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [QTY_W-1:0] req_qty,
  output logic             req_ready,
  output logic             position_select,
  output logic             busy,
  output logic [QTY_W-1:0] items_left,
`ifdef SERVO_DISPENSE_TOTAL_EN
  output logic [15:0]      total_dispensed,
`endif
  output logic             done
);

  localparam longint unsigned HOLD_CNT_L = ms_to_cycles(64'(CLK_FREQ), 64'(HOLD_MS));
  localparam longint unsigned RET_CNT_L  = ms_to_cycles(64'(CLK_FREQ), 64'(RETURN_MS));
  localparam logic [TIMER_W-1:0] HOLD_CNT = HOLD_CNT_L[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] RET_CNT  = RET_CNT_L[TIMER_W-1:0];

  // Both phase lengths must be at least one cycle and fit the timer.
  if (HOLD_CNT_L < 64'd1 || HOLD_CNT_L > 64'hFFFF_FFFF) begin : g_bad_hold
    $error("servo_dispense_ctrl: HOLD_CNT must be in 1..2^32-1");
  end
  if (RET_CNT_L < 64'd1 || RET_CNT_L > 64'hFFFF_FFFF) begin : g_bad_ret
    $error("servo_dispense_ctrl: RET_CNT must be in 1..2^32-1");
  end

  state_e           state_q, state_d;
  logic [QTY_W-1:0] items_left_q, items_left_d;
  logic             done_q, done_d;
  logic             position_select_q, position_select_d;
  logic             busy_q, busy_d;
  logic             req_ready_q, req_ready_d;
  logic             accept;
  logic             timer_expire;
  logic             timer_clear;
  logic             timer_enable;
  logic [TIMER_W-1:0] timer_term;
`ifdef SERVO_DISPENSE_TOTAL_EN
  logic [15:0]      total_q, total_d;
`endif

  assign accept = req_valid && req_ready_q;

  // One timer serves both motion phases; it restarts whenever the phase
  // changes and sits at zero while idle.
  assign timer_enable = (state_q != ST_IDLE);
  assign timer_clear  = (state_q == ST_IDLE) || timer_expire;
  assign timer_term   = (state_q == ST_EXTEND) ? HOLD_CNT : RET_CNT;

  dispense_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (timer_enable),
    .term_cnt   (timer_term),
    .expire     (timer_expire)
  );

  // State and registered outputs. Reset drops the servo to rest immediately
  // and throws away any partially completed request without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      items_left_q      <= '0;
      done_q            <= 1'b0;
      position_select_q <= 1'b0;
      busy_q            <= 1'b0;
      req_ready_q       <= 1'b1;
`ifdef SERVO_DISPENSE_TOTAL_EN
      total_q           <= '0;
`endif
    end else begin
      state_q           <= state_d;
      items_left_q      <= items_left_d;
      done_q            <= done_d;
      position_select_q <= position_select_d;
      busy_q            <= busy_d;
      req_ready_q       <= req_ready_d;
`ifdef SERVO_DISPENSE_TOTAL_EN
      total_q           <= total_d;
`endif
    end
  end

  // Next-state logic. A zero-quantity request completes on the spot; otherwise
  // each item is one EXTEND phase followed by one RETRACT phase, and the item
  // count drops on the last RETRACT cycle.
  always_comb begin
    state_d      = state_q;
    items_left_d = items_left_q;
    done_d       = 1'b0;
`ifdef SERVO_DISPENSE_TOTAL_EN
    total_d      = total_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_qty != '0) begin
            items_left_d = req_qty;
            state_d      = ST_EXTEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_EXTEND: begin
        if (timer_expire) begin
          state_d = ST_RETRACT;
        end
      end
      ST_RETRACT: begin
        if (timer_expire) begin
          if (items_left_q != '0) begin
            items_left_d = items_left_q - QTY_W'(1);
          end
`ifdef SERVO_DISPENSE_TOTAL_EN
          if (total_q != 16'hFFFF) begin
            total_d = total_q + 16'd1;
          end
`endif
          if (items_left_q <= QTY_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_EXTEND;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so that they line up with the state
  // they describe from its very first cycle.
  always_comb begin
    position_select_d = (state_d == ST_EXTEND);
    busy_d            = (state_d != ST_IDLE);
    req_ready_d       = (state_d == ST_IDLE);
  end

  assign req_ready       = req_ready_q;
  assign position_select = position_select_q;
  assign busy            = busy_q;
  assign items_left      = items_left_q;
  assign done            = done_q;
`ifdef SERVO_DISPENSE_TOTAL_EN
  assign total_dispensed = total_q;
`endif

endmodule
